// File: rtl/core_run_ctrl.sv
// Boot and run sequencer: streams a host program into instruction memory, holds the
// core in reset for a fixed time, then runs it until the PC stalls (halt).
module core_run_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int IM_ADDR_WIDTH = 10,
    parameter int RESET_CYCLES  = 4,
    parameter int HALT_CYCLES   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic [IM_ADDR_WIDTH:0]   load_len_i,
    input  logic                     s_valid_i,
    input  logic [DATA_WIDTH-1:0]    s_data_i,
    output logic                     s_ready_o,
    output logic                     im_we_o,
    output logic [IM_ADDR_WIDTH-1:0] im_waddr_o,
    output logic [DATA_WIDTH-1:0]    im_wdata_o,
    output logic                     core_rst_o,
    input  logic [IM_ADDR_WIDTH-1:0] core_pc_i,
    output logic [2:0]               state_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic [IM_ADDR_WIDTH-1:0] halt_pc_o,
    output logic [31:0]              cycle_cnt_o
);

    localparam int REL_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
    localparam int STB_W = $clog2(HALT_CYCLES);

    localparam logic [IM_ADDR_WIDTH:0]   LEN_ONE  = 1;
    localparam logic [IM_ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [REL_W-1:0]         REL_ONE  = 1;
    localparam logic [REL_W-1:0]         REL_INIT = REL_W'(RESET_CYCLES - 1);
    localparam logic [STB_W-1:0]         STB_ONE  = 1;
    localparam logic [STB_W-1:0]         STB_LAST = STB_W'(HALT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        HALT    = 3'd4
    } state_t;

    state_t                   state;
    state_t                   state_nxt;
    logic [IM_ADDR_WIDTH:0]   remaining;
    logic [IM_ADDR_WIDTH-1:0] waddr;
    logic [IM_ADDR_WIDTH-1:0] pc_q;
    logic [REL_W-1:0]         rel_cnt;
    logic [STB_W-1:0]         stable;
    logic                     first_run;

    logic handshake;
    logic write_go;
    logic start_ok;
    logic pc_match;
    logic halt_hit;
    logic run_entry;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    assign s_ready_o = (state == LOAD);
    assign state_o   = state;
    assign handshake = s_valid_i & s_ready_o;
    assign write_go  = handshake & ~abort_i;
    assign start_ok  = start_i & ~abort_i & ((state == IDLE) | (state == HALT));
    // The first RUN cycle only primes pc_q; it can never count as a stall.
    assign pc_match  = (state == RUN) & ~first_run & (core_pc_i == pc_q);
    assign halt_hit  = pc_match & (stable == STB_LAST);
    assign run_entry = (state == RELEASE) & (state_nxt == RUN);

    always_comb begin
        state_nxt = state;
        if (abort_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE, HALT: begin
                    if (start_i) state_nxt = (load_len_i != '0) ? LOAD : RELEASE;
                end
                LOAD: begin
                    if (handshake && (remaining == LEN_ONE)) state_nxt = RELEASE;
                end
                RELEASE: begin
                    if (rel_cnt == '0) state_nxt = RUN;
                end
                RUN: begin
                    if (halt_hit) state_nxt = HALT;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            core_rst_o  <= 1'b1;
            busy_o      <= 1'b0;
            done_o      <= 1'b0;
            im_we_o     <= 1'b0;
            im_waddr_o  <= '0;
            im_wdata_o  <= '0;
            halt_pc_o   <= '0;
            cycle_cnt_o <= '0;
            remaining   <= '0;
            waddr       <= '0;
            rel_cnt     <= '0;
            pc_q        <= '0;
            stable      <= '0;
            first_run   <= 1'b1;
        end else begin
            // ---- state and status outputs, registered from the next state
            state      <= state_nxt;
            core_rst_o <= (state_nxt != RUN);
            busy_o     <= (state_nxt == LOAD) || (state_nxt == RELEASE) || (state_nxt == RUN);
            done_o     <= (state_nxt == HALT);

            // ---- program load: one-cycle write latency, address wraps naturally
            im_we_o <= write_go;
            if (write_go) begin
                im_waddr_o <= waddr;
                im_wdata_o <= s_data_i;
                waddr      <= waddr + ADDR_ONE;
                remaining  <= remaining - LEN_ONE;
            end
            if (start_ok) begin
                remaining   <= load_len_i;
                waddr       <= '0;
                cycle_cnt_o <= '0;
            end

            // ---- reset-release countdown
            if ((state_nxt == RELEASE) && (state != RELEASE)) begin
                rel_cnt <= REL_INIT;
            end else if ((state == RELEASE) && (rel_cnt != '0)) begin
                rel_cnt <= rel_cnt - REL_ONE;
            end

            // ---- run monitoring and halt detection
            if (run_entry) begin
                pc_q      <= '0;
                stable    <= '0;
                first_run <= 1'b1;
            end else if ((state == RUN) && !abort_i) begin
                pc_q        <= core_pc_i;
                first_run   <= 1'b0;
                cycle_cnt_o <= sat_inc(cycle_cnt_o);
                if (halt_hit) begin
                    halt_pc_o <= core_pc_i;
                end else if (pc_match) begin
                    stable <= stable + STB_ONE;
                end else begin
                    stable <= '0;
                end
            end
        end
    end

endmodule
